reu_dma_seq_mc: RTL

- Multi-channel successor to the single-channel REU DMA sequencer.
- Arbitrates among NCH independent transfer requests and owns a per-transfer length counter; Length1 is no longer an input.
- Adds a correctly pipelined C64-to-REU write phase, abort, and per-channel completion strobes.
- Sits between the register file (per-channel type/length/strobes) and the REU address counters/RAM controller.

---
 rtl/reu_dma_seq_mc.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/reu_dma_seq_mc.sv
// reu_dma_seq_mc: multi-channel REU DMA sequencer with round-robin grant,
// per-transfer length counter, pipelined C64->REU writes, abort, Done strobes.
// Ports:
//   PHI2, nRESET        clock (state on falling edge), async active-low reset
//   BA, Equal           bus available, verify compare result
//   Execute, Abort      per-channel start strobes, terminate active transfer
//   XferType, LenLoad   per-channel mode (2 bits) and start length
//   DMA, DMARW          DMA active, 1 = C64 read / 0 = C64 write
//   RAMRD, RAMWR        REU RAM read / write enables
//   Chan, LenRemain     granted channel, remaining byte count
//   NextCA, NextREUA    address advance strobes (combinational)
//   XferEnd, VerifyErr  final byte / verify mismatch (combinational)
//   Done                one-cycle completion pulse per channel
module reu_dma_seq_mc #(
    parameter int NCH   = 2,
    parameter int CH_W  = 1,
    parameter int LEN_W = 16
) (
    input  logic                   PHI2,
    input  logic                   nRESET,
    input  logic                   BA,
    input  logic                   Equal,
    input  logic [NCH-1:0]         Execute,
    input  logic                   Abort,
    input  logic [2*NCH-1:0]       XferType,
    input  logic [NCH*LEN_W-1:0]   LenLoad,
    output logic                   DMA,
    output logic                   DMARW,
    output logic                   RAMRD,
    output logic                   RAMWR,
    output logic [CH_W-1:0]        Chan,
    output logic [LEN_W-1:0]       LenRemain,
    output logic                   NextCA,
    output logic                   NextREUA,
    output logic                   XferEnd,
    output logic                   VerifyErr,
    output logic [NCH-1:0]         Done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_n;
    logic [NCH-1:0]    pend, pend_n;
    logic              swapph, swap_n;
    logic              wrpend, wrpend_n;
    logic [CH_W-1:0]   ptr, ptr_n;

    logic              dma_n, rw_n, rd_n, wr_n;
    logic [CH_W-1:0]   chan_n;
    logic [LEN_W-1:0]  len_n;
    logic [NCH-1:0]    done_n;

    logic [1:0]        typ   [NCH];
    logic [LEN_W-1:0]  lenld [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign typ[g]   = XferType[2*g +: 2];
        assign lenld[g] = LenLoad[g*LEN_W +: LEN_W];
    end

    // {DMARW, RAMRD, RAMWR} loaded before the first cycle of a transfer
    function automatic logic [2:0] preset(input logic [1:0] t);
        logic [2:0] p;
        p = 3'b110;
        if (t == 2'b00) p = 3'b100;
        if (t == 2'b01) p = 3'b010;
        return p;
    endfunction

    // round-robin candidate: first pending at or after ptr, with wrap
    logic              found;
    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   idx;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = CH_W'((int'(ptr) + k) % NCH);
            if (!found && pend[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
    end

    logic [1:0] cur;
    logic       cyc, unit, verr, last, abrt;

    assign cur  = typ[Chan];
    assign cyc  = DMA & BA;
    // swap phase 0 is only the first half of a byte
    assign unit = cyc & ~((cur == 2'b10) & ~swapph);
    assign verr = cyc & (cur == 2'b11) & ~Equal;
    assign last = unit & ((LenRemain == LEN_W'(1)) | verr);
    assign abrt = Abort & DMA;

    assign NextCA    = unit;
    // C64->REU: RAM write (and REU address step) lags the C64 read by one cycle
    assign NextREUA  = (cur == 2'b00) ? wrpend : unit;
    assign XferEnd   = last & ~Abort;
    assign VerifyErr = verr;

    always_comb begin
        state_n  = state;
        dma_n    = DMA;
        rw_n     = DMARW;
        rd_n     = RAMRD;
        wr_n     = RAMWR;
        chan_n   = Chan;
        len_n    = LenRemain;
        done_n   = '0;
        pend_n   = pend;
        swap_n   = swapph;
        ptr_n    = ptr;
        wrpend_n = cyc & ~Abort;

        unique case (state)
            IDLE: begin
                {rw_n, rd_n, wr_n} = preset(typ[cand]);
                swap_n = 1'b0;
                if (found) begin
                    state_n      = RUN;
                    dma_n        = 1'b1;
                    chan_n       = cand;
                    len_n        = lenld[cand];
                    ptr_n        = CH_W'((int'(cand) + 1) % NCH);
                    pend_n[cand] = 1'b0;
                end
            end
            RUN: begin
                if (abrt) begin
                    state_n            = IDLE;
                    dma_n              = 1'b0;
                    swap_n             = 1'b0;
                    wrpend_n           = 1'b0;
                    pend_n[Chan]       = 1'b0;
                    {rw_n, rd_n, wr_n} = preset(typ[cand]);
                end else if (cyc) begin
                    unique case (cur)
                        2'b00: {rw_n, rd_n, wr_n} = 3'b101;
                        2'b01: {rw_n, rd_n, wr_n} = 3'b010;
                        2'b10: {rw_n, rd_n, wr_n} = swapph ? 3'b110 : 3'b001;
                        default: {rw_n, rd_n, wr_n} = 3'b110;
                    endcase
                    swap_n = (cur == 2'b10) ? ~swapph : 1'b0;
                    if (unit) len_n = LenRemain - LEN_W'(1);
                    if (last) begin
                        state_n            = IDLE;
                        dma_n              = 1'b0;
                        swap_n             = 1'b0;
                        done_n[Chan]       = 1'b1;
                        {rw_n, rd_n, wr_n} = preset(typ[cand]);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // a strobe during its own transfer re-arms the channel
        pend_n = pend_n | Execute;
    end

    always_ff @(negedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            state     <= IDLE;
            DMA       <= 1'b0;
            DMARW     <= 1'b1;
            RAMRD     <= 1'b0;
            RAMWR     <= 1'b0;
            Chan      <= '0;
            LenRemain <= '0;
            Done      <= '0;
            pend      <= '0;
            swapph    <= 1'b0;
            wrpend    <= 1'b0;
            ptr       <= '0;
        end else begin
            state     <= state_n;
            DMA       <= dma_n;
            DMARW     <= rw_n;
            RAMRD     <= rd_n;
            RAMWR     <= wr_n;
            Chan      <= chan_n;
            LenRemain <= len_n;
            Done      <= done_n;
            pend      <= pend_n;
            swapph    <= swap_n;
            wrpend    <= wrpend_n;
            ptr       <= ptr_n;
        end
    end

endmodule
